cnn_cmd_scheduler: RTL and testbench

// Sequences the CNN engine from a queued host command stream. Buffers commands, frames setup_en/in_valid bursts

---
 rtl/cnn_cmd_scheduler_pkg.sv | 40 ++++
 rtl/cnn_cmd_scheduler_if.sv | 37 +++
 rtl/cnn_cmd_scheduler_fifo.sv | 60 ++++++
 rtl/cnn_cmd_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_cnn_cmd_scheduler.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/cnn_cmd_scheduler_pkg.sv
// Shared encodings for the CNN command scheduler: opcodes, FSM states,
// error bit positions and the size-code to word-count lookup.
package cnn_sched_pkg;

   typedef enum logic [2:0] {
      OP_SETUP = 3'd0,
      OP_CONV  = 3'd1,
      OP_RELU  = 3'd2,
      OP_POOL  = 3'd3,
      OP_FULL  = 3'd4
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CHECK,
      S_ISSUE,
      S_WAIT,
      S_DRAIN,
      S_GAP
   } state_e;

   localparam int unsigned ERR_OP       = 0;
   localparam int unsigned ERR_POOL     = 1;
   localparam int unsigned ERR_UNDERRUN = 2;
   localparam int unsigned ERR_TIMEOUT  = 3;

   localparam int unsigned CNT_W = 9;

   // Size code 0..3 maps to side 16/8/4/2; returns N = side*side.
   function automatic logic [CNT_W-1:0] size_words(input logic [1:0] code);
      case (code)
         2'd0:    return 9'd256;
         2'd1:    return 9'd64;
         2'd2:    return 9'd16;
         default: return 9'd4;
      endcase
   endfunction

endpackage

// File: rtl/cnn_cmd_scheduler_if.sv
// Host command/operand, engine and result signals of the CNN command scheduler.
interface cnn_cmd_scheduler_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [1:0]  cmd_size;
   logic        dat_valid;
   logic        dat_ready;
   logic [31:0] dat_in;
   logic        eng_setup_en;
   logic        eng_in_valid;
   logic [31:0] eng_in_data;
   logic [1:0]  eng_action;
   logic [1:0]  eng_size;
   logic        eng_out_valid;
   logic [31:0] eng_out_data;
   logic        res_valid;
   logic [31:0] res_data;
   logic        res_last;
   logic        busy;
   logic [3:0]  err;
   logic        err_clr;

   modport master (
      output cmd_valid, cmd_op, cmd_size, dat_valid, dat_in,
             eng_out_valid, eng_out_data, err_clr,
      input  cmd_ready, dat_ready, eng_setup_en, eng_in_valid, eng_in_data,
             eng_action, eng_size, res_valid, res_data, res_last, busy, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_size, dat_valid, dat_in,
             eng_out_valid, eng_out_data, err_clr,
      output cmd_ready, dat_ready, eng_setup_en, eng_in_valid, eng_in_data,
             eng_action, eng_size, res_valid, res_data, res_last, busy, err
   );
endinterface

// File: rtl/cnn_cmd_scheduler_fifo.sv
// Synchronous show-ahead command FIFO with registered full/empty flags.
module cnn_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         rd_en_i,
   output logic [W-1:0] rd_data_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full_q, empty_q;
   logic          do_wr, do_rd;

   // A write while full is accepted when the same cycle also pops.
   assign do_rd = rd_en_i & ~empty_q;
   assign do_wr = wr_en_i & (~full_q | do_rd);

   always_comb begin
      cnt_d = cnt_q;
      if (do_wr && !do_rd)
         cnt_d = cnt_q + 1'b1;
      else if (do_rd && !do_wr)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (do_wr) wptr_q <= wptr_q + 1'b1;
         if (do_rd) rptr_q <= rptr_q + 1'b1;
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == (AW+1)'(DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rptr_q];
   assign empty_o   = empty_q;
   assign full_o    = full_q;

endmodule

// File: rtl/cnn_cmd_scheduler.sv
// Sequences one queued command at a time onto the CNN engine, frames the
// operand burst, collects the result burst and records sticky faults.
module cnn_cmd_scheduler
   import cnn_sched_pkg::*;
#(
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned TIMEOUT   = 1024,
   parameter int unsigned GAP       = 1
) (
   input logic          clk,
   input logic          rst,
   cnn_cmd_scheduler_if.slave sif
);

   localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [1:0]       size_q, size_d;
   logic [1:0]       dim_q, dim_d;
   logic             dim_vld_q, dim_vld_d;
   logic [CNT_W-1:0] words_q, words_d;
   logic [CNT_W-1:0] exp_q, exp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             started_q, started_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [GAP_W-1:0] gcnt_q, gcnt_d;
   logic [3:0]       err_q, err_d;
   logic             res_valid_q, res_valid_d;
   logic [31:0]      res_data_q, res_data_d;
   logic             res_last_q, res_last_d;

   logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
   logic [4:0]       fifo_rdata;
   logic [3:0]       new_err;
   logic [CNT_W-1:0] rx;
   logic             issuing;
   logic             dat_ready, setup_en, in_valid;
   logic [31:0]      in_data;
   logic [1:0]       action, eng_size;

   assign fifo_push = sif.cmd_valid & ~fifo_full;

   cnn_cmd_fifo #(.DEPTH(CMD_DEPTH), .W(5)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (fifo_push),
      .wr_data_i ({sif.cmd_op, sif.cmd_size}),
      .rd_en_i   (fifo_pop),
      .rd_data_o (fifo_rdata),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      size_d      = size_q;
      dim_d       = dim_q;
      dim_vld_d   = dim_vld_q;
      words_d     = words_q;
      exp_d       = exp_q;
      cnt_d       = cnt_q;
      started_d   = started_q;
      wd_d        = wd_q;
      gcnt_d      = gcnt_q;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      res_last_d  = 1'b0;
      new_err     = '0;
      rx          = '0;
      issuing     = 1'b0;
      fifo_pop    = 1'b0;
      dat_ready   = 1'b0;
      setup_en    = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      action      = '0;
      eng_size    = '0;

      case (state_q)
         S_IDLE: if (!fifo_empty) state_d = S_FETCH;
         S_FETCH: begin
            fifo_pop = 1'b1;
            op_d     = fifo_rdata[4:2];
            size_d   = fifo_rdata[1:0];
            state_d  = S_CHECK;
         end
         S_CHECK: begin
            cnt_d     = '0;
            started_d = 1'b0;
            gcnt_d    = '0;
            if (op_q > OP_FULL || (op_q != OP_SETUP && !dim_vld_q)) begin
               new_err[ERR_OP] = 1'b1;
               state_d         = S_GAP;
            end else if (op_q == OP_POOL && dim_q == 2'd3) begin
               new_err[ERR_POOL] = 1'b1;
               state_d           = S_GAP;
            end else begin
               state_d = S_ISSUE;
               case (op_q)
                  OP_SETUP: begin words_d = size_words(size_q); exp_d = size_words(size_q); end
                  OP_CONV:  begin words_d = 9'd9; exp_d = size_words(dim_q); end
                  OP_RELU:  begin words_d = 9'd1; exp_d = size_words(dim_q); end
                  OP_POOL:  begin words_d = 9'd1; exp_d = size_words(dim_q + 2'd1); end
                  default:  begin words_d = size_words(dim_q); exp_d = size_words(dim_q); end
               endcase
            end
         end
         S_ISSUE: begin
            dat_ready = 1'b1;
            case (op_q)
               OP_RELU: action = 2'd1;
               OP_POOL: action = 2'd2;
               OP_FULL: action = 2'd3;
               default: action = 2'd0;
            endcase
            if (op_q == OP_SETUP) eng_size = size_q;
            // Once the first word goes out the burst runs to length, zero-filling gaps.
            issuing = started_q | sif.dat_valid;
            if (issuing) begin
               started_d = 1'b1;
               if (op_q == OP_SETUP) setup_en = 1'b1;
               else                  in_valid = 1'b1;
               in_data = sif.dat_valid ? sif.dat_in : '0;
               if (started_q && !sif.dat_valid) new_err[ERR_UNDERRUN] = 1'b1;
               if (op_q == OP_SETUP && !started_q) begin
                  dim_d     = size_q;
                  dim_vld_d = 1'b1;
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == words_q - 1'b1) begin
                  cnt_d   = '0;
                  wd_d    = '0;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT, S_DRAIN: begin
            if (sif.eng_out_valid) begin
               rx          = (state_q == S_WAIT) ? 9'd1 : cnt_q + 1'b1;
               cnt_d       = rx;
               res_valid_d = 1'b1;
               res_data_d  = sif.eng_out_data;
               state_d     = S_DRAIN;
               if (rx == exp_q) begin
                  res_last_d = 1'b1;
                  gcnt_d     = '0;
                  state_d    = S_GAP;
                  if (op_q == OP_POOL) dim_d = dim_q + 2'd1;
               end
            end else if (state_q == S_WAIT) begin
               if (wd_q == WD_W'(TIMEOUT - 1)) begin
                  new_err[ERR_TIMEOUT] = 1'b1;
                  gcnt_d               = '0;
                  state_d              = S_GAP;
               end else begin
                  wd_d = wd_q + 1'b1;
               end
            end
         end
         S_GAP: begin
            if (gcnt_q == GAP_W'(GAP - 1))
               state_d = fifo_empty ? S_IDLE : S_FETCH;
            else
               gcnt_d = gcnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      err_d = (sif.err_clr ? 4'b0000 : err_q) | new_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         size_q      <= '0;
         dim_q       <= '0;
         dim_vld_q   <= 1'b0;
         words_q     <= '0;
         exp_q       <= '0;
         cnt_q       <= '0;
         started_q   <= 1'b0;
         wd_q        <= '0;
         gcnt_q      <= '0;
         err_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         size_q      <= size_d;
         dim_q       <= dim_d;
         dim_vld_q   <= dim_vld_d;
         words_q     <= words_d;
         exp_q       <= exp_d;
         cnt_q       <= cnt_d;
         started_q   <= started_d;
         wd_q        <= wd_d;
         gcnt_q      <= gcnt_d;
         err_q       <= err_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_last_q  <= res_last_d;
      end
   end

   assign sif.cmd_ready    = ~fifo_full;
   assign sif.dat_ready    = dat_ready;
   assign sif.eng_setup_en = setup_en;
   assign sif.eng_in_valid = in_valid;
   assign sif.eng_in_data  = in_data;
   assign sif.eng_action   = action;
   assign sif.eng_size     = eng_size;
   assign sif.res_valid    = res_valid_q;
   assign sif.res_data     = res_data_q;
   assign sif.res_last     = res_last_q;
   assign sif.busy         = (state_q != S_IDLE) | ~fifo_empty;
   assign sif.err          = err_q;

endmodule

// File: tb/tb_cnn_cmd_scheduler.sv
// Directed bench for cnn_cmd_scheduler: drives commands/operands, plays the
// engine, and scoreboards the forwarded result bursts.
module tb_cnn_cmd_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   en_cycles = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   cnn_cmd_scheduler_if sif();

   cnn_cmd_scheduler #(.CMD_DEPTH(4), .TIMEOUT(16), .GAP(1)) dut (
      .clk (clk),
      .rst (rst),
      .sif (sif)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (sif.eng_in_valid | sif.eng_setup_en) en_cycles++;
   end

   always @(negedge clk) begin
      logic [32:0] e;
      #2;
      if (sif.res_valid) begin
         chk("res_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("res_data", sif.res_data, e[31:0]);
            chk("res_last", 32'(sif.res_last), 32'(e[32]));
         end
      end
   end

   task automatic push_cmd(input logic [2:0] op, input logic [1:0] sz);
      int k = 0;
      @(negedge clk);
      while (!sif.cmd_ready && k < 100) begin @(negedge clk); k++; end
      chk("cmd_ready", 32'(sif.cmd_ready), 32'd1);
      sif.cmd_valid = 1'b1;
      sif.cmd_op    = op;
      sif.cmd_size  = sz;
      @(posedge clk); #1;
      sif.cmd_valid = 1'b0;
   endtask

   task automatic issue(input int n, input logic [31:0] base, input int drop,
                        input bit setup, input logic [1:0] act, input logic [1:0] sz);
      int k = 0;
      @(negedge clk);
      while (!sif.dat_ready && k < 50) begin @(negedge clk); k++; end
      chk("dat_ready_wait", 32'(sif.dat_ready), 32'd1);
      for (int i = 0; i < n; i++) begin
         sif.dat_valid = (i != drop);
         sif.dat_in    = base + 32'(i);
         #1;
         chk(setup ? "setup_en" : "in_valid",
             32'(setup ? sif.eng_setup_en : sif.eng_in_valid), 32'd1);
         chk("in_data", sif.eng_in_data, (i == drop) ? 32'd0 : base + 32'(i));
         chk("action", 32'(sif.eng_action), 32'(act));
         if (setup) chk("eng_size", 32'(sif.eng_size), 32'(sz));
         @(negedge clk);
      end
      sif.dat_valid = 1'b0;
      sif.dat_in    = '0;
      #1;
      chk("burst_end", 32'(sif.eng_in_valid | sif.eng_setup_en), 32'd0);
   endtask

   task automatic respond(input int m, input logic [31:0] base);
      for (int k = 0; k < m; k++) begin
         @(negedge clk);
         sif.eng_out_valid = 1'b1;
         sif.eng_out_data  = base + 32'(k);
         exp_q.push_back({k == m - 1, base + 32'(k)});
      end
      @(negedge clk);
      sif.eng_out_valid = 1'b0;
      sif.eng_out_data  = '0;
   endtask

   task automatic settle();
      int k = 0;
      @(negedge clk); #3;
      while (sif.busy && k < 300) begin @(negedge clk); #3; k++; end
      chk("settle_busy", 32'(sif.busy), 32'd0);
      chk("res_pending", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      sif.err_clr = 1'b1;
      @(posedge clk); #1;
      sif.err_clr = 1'b0;
      chk("err_cleared", 32'(sif.err), 32'd0);
   endtask

   initial begin
      int k;
      int en0;
      sif.cmd_valid     = 1'b0;
      sif.cmd_op        = '0;
      sif.cmd_size      = '0;
      sif.dat_valid     = 1'b0;
      sif.dat_in        = '0;
      sif.eng_out_valid = 1'b0;
      sif.eng_out_data  = '0;
      sif.err_clr       = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_cmd_ready", 32'(sif.cmd_ready), 32'd1);
      chk("rst_busy", 32'(sif.busy), 32'd0);
      chk("rst_err", 32'(sif.err), 32'd0);
      chk("rst_dat_ready", 32'(sif.dat_ready), 32'd0);
      chk("rst_in_valid", 32'(sif.eng_in_valid | sif.eng_setup_en), 32'd0);
      chk("rst_res_valid", 32'(sif.res_valid), 32'd0);

      // Commands before any SETUP and an illegal opcode
      push_cmd(3'd1, 2'd0);
      settle();
      chk("err_no_setup", 32'(sif.err), 32'h1);
      pulse_clr();
      push_cmd(3'd6, 2'd0);
      settle();
      chk("err_illegal_op", 32'(sif.err), 32'h1);
      pulse_clr();
      chk("no_issue_on_fault", 32'(en_cycles), 32'd0);

      // SETUP 4x4: 16 setup words, 16 results
      push_cmd(3'd0, 2'd2);
      issue(16, 32'd1, -1, 1'b1, 2'd0, 2'd2);
      respond(16, 32'h100);
      settle();
      chk("err_setup", 32'(sif.err), 32'h0);

      // POOL 4x4 -> 2x2, then FULL on 2x2
      push_cmd(3'd3, 2'd0);
      issue(1, 32'hA0, -1, 1'b0, 2'd2, 2'd0);
      respond(4, 32'h200);
      settle();
      push_cmd(3'd4, 2'd0);
      issue(4, 32'hB0, -1, 1'b0, 2'd3, 2'd0);
      respond(4, 32'h300);
      settle();
      chk("err_full", 32'(sif.err), 32'h0);

      // POOL at 2x2 is dropped; RELU afterwards still runs
      push_cmd(3'd0, 2'd3);
      issue(4, 32'hD0, -1, 1'b1, 2'd0, 2'd3);
      respond(4, 32'h400);
      settle();
      en0 = en_cycles;
      push_cmd(3'd3, 2'd0);
      settle();
      chk("err_pool_2x2", 32'(sif.err), 32'h2);
      chk("pool_dropped", 32'(en_cycles - en0), 32'd0);
      push_cmd(3'd2, 2'd0);
      issue(1, 32'hE0, -1, 1'b0, 2'd1, 2'd0);
      respond(4, 32'h500);
      settle();
      chk("err_sticky", 32'(sif.err), 32'h2);
      pulse_clr();

      // CONV with operand missing on the 5th word
      push_cmd(3'd1, 2'd0);
      issue(9, 32'hC0, 4, 1'b0, 2'd0, 2'd0);
      chk("err_underrun", 32'(sif.err), 32'h4);
      respond(4, 32'h600);
      settle();
      pulse_clr();

      // Timeout with four RELUs queued behind the stalled CONV
      push_cmd(3'd1, 2'd0);
      for (int i = 0; i < 4; i++) push_cmd(3'd2, 2'd0);
      @(negedge clk); #1;
      chk("fifo_full_ready", 32'(sif.cmd_ready), 32'd0);
      chk("fifo_full_busy", 32'(sif.busy), 32'd1);
      issue(9, 32'hF0, -1, 1'b0, 2'd0, 2'd0);
      k = 0;
      do begin @(posedge clk); #1; k++; end while (!sif.err[3] && k < 40);
      chk("timeout_cycles", 32'(k), 32'd16);
      chk("err_timeout", 32'(sif.err), 32'h8);
      for (int i = 0; i < 4; i++) begin
         issue(1, 32'h700 + 32'(i), -1, 1'b0, 2'd1, 2'd0);
         respond(4, 32'h800 + 32'(16 * i));
      end
      settle();
      chk("err_final", 32'(sif.err), 32'h8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL global_timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "bench time limit");
   end

endmodule
